mc_mem_responder: RTL and testbench

Memory-side responder for the multicycle MIPS datapath. It services the instruction-fetch and load/store requests that the controller issues through MemRead/MemWrite and the IorD-selected address, using a configurable wait-state counter and a one-cycle ready pulse. The controller stalls on this pulse. The block sits between the datapath address/write-data buses and a single-port word array, and returns read data and an error flag.

---
 rtl/mc_mem_pkg.sv | 25 ++
 rtl/mc_mem_array.sv | 37 +++
 rtl/mc_mem_responder.sv | 157 +++++++++++++++
 tb/tb_mc_mem_responder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mc_mem_pkg.sv
// -----------------------------------------------------------------------------
// mc_mem_pkg
// Shared types and constants for the multicycle MIPS memory responder.
//   mem_state_t : responder FSM states (IDLE, BUSY, RESP)
//   mem_op_t    : latched operation kind (OP_RD, OP_WR)
//   WORD_W      : data word width
//   CNT_W       : wait-state counter width (latencies 1..15)
// -----------------------------------------------------------------------------
package mc_mem_pkg;

   localparam int WORD_W = 32;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } mem_state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } mem_op_t;

endpackage

// File: rtl/mc_mem_array.sv
// -----------------------------------------------------------------------------
// mc_mem_array
// Synchronous single-port word RAM with write enable and registered read.
// The read register only updates when i_re is high, so o_rd holds the last
// word read until the next read.
//   clk   : clock
//   i_we  : write enable
//   i_re  : read enable
//   i_idx : word index
//   i_wd  : write data
//   o_rd  : registered read data
// -----------------------------------------------------------------------------
module mc_mem_array
   import mc_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic              i_re,
   input  logic [AW-1:0]     i_idx,
   input  logic [WORD_W-1:0] i_wd,
   output logic [WORD_W-1:0] o_rd
);

   logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
   logic [WORD_W-1:0] r_rd;

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_idx] <= i_wd;
      if (i_re) r_rd <= r_mem[i_idx];
   end

   assign o_rd = r_rd;

endmodule

// File: rtl/mc_mem_responder.sv
// -----------------------------------------------------------------------------
// mc_mem_responder
// Memory-side responder for the multicycle MIPS datapath. Accepts one read or
// write request at a time, waits a configurable number of cycles, performs the
// array access and returns a one-cycle ready pulse qualified by error.
//   clk, rst   : clock, asynchronous active-high reset
//   mem_read   : read request, held until ready
//   mem_write  : write request, held until ready
//   addr       : byte address (word index = addr[31:2])
//   wdata      : write data, latched at acceptance
//   rdata      : read data, held until the next completed read
//   ready      : one-cycle completion pulse
//   error      : access rejected (conflict, out of range, misaligned)
//   busy       : high while in BUSY or RESP
// Optional feature macro: MEM_ALIGN_CHECK_EN (reject addr[1:0] != 0).
// -----------------------------------------------------------------------------
module mc_mem_responder
   import mc_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int RD_LATENCY  = 2,
   parameter int WR_LATENCY  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [31:0]       addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata,
   output logic              ready,
   output logic              error,
   output logic              busy
);

   localparam int AW = $clog2(DEPTH_WORDS);

   mem_state_t        r_state;
   mem_op_t           r_op;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_ready;
   logic              r_error;
   logic              r_busy;
   logic              r_rd_zero;
   logic [29:0]       r_idx;
   logic [WORD_W-1:0] r_wdata;
   logic              r_misalign;

   logic              w_one_req;
   logic              w_req_live;
   logic              w_bad;
   logic              w_done;
   logic              w_we;
   logic              w_re;
   logic              w_misalign_in;
   logic [WORD_W-1:0] w_ram_rd;

`ifdef MEM_ALIGN_CHECK_EN
   assign w_misalign_in = (addr[1:0] != 2'b00);
`else
   // Byte-offset bits are ignored; the access is forced word-aligned.
   assign w_misalign_in = 1'b0 & (|addr[1:0]);
`endif

   assign w_one_req  = mem_read ^ mem_write;
   // The held request line of the latched op decides whether we keep going.
   assign w_req_live = (r_op == OP_RD) ? mem_read : mem_write;
   assign w_bad      = (r_idx >= 30'(DEPTH_WORDS)) | r_misalign;
   assign w_done     = (r_state == BUSY) && w_req_live && (r_cnt == '0);
   // Enables derive from the reset-cleared state, so an asserted rst blocks a
   // pending commit immediately.
   assign w_we       = w_done && (r_op == OP_WR) && !w_bad;
   assign w_re       = w_done && (r_op == OP_RD) && !w_bad;

   // Request operands are data, latched only on acceptance.
   always_ff @(posedge clk) begin
      if (r_state == IDLE && w_one_req) begin
         r_idx      <= addr[31:2];
         r_wdata    <= wdata;
         r_misalign <= w_misalign_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_op      <= OP_RD;
         r_cnt     <= '0;
         r_ready   <= 1'b0;
         r_error   <= 1'b0;
         r_busy    <= 1'b0;
         r_rd_zero <= 1'b1;
      end else begin
         r_ready <= 1'b0;
         r_error <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_one_req) begin
                  r_op    <= mem_write ? OP_WR : OP_RD;
                  r_cnt   <= mem_write ? CNT_W'(WR_LATENCY - 1) : CNT_W'(RD_LATENCY - 1);
                  r_state <= BUSY;
                  r_busy  <= 1'b1;
               end else if (mem_read && mem_write) begin
                  // Conflicting request: reject at once, no array access.
                  r_state <= RESP;
                  r_ready <= 1'b1;
                  r_error <= 1'b1;
                  r_busy  <= 1'b1;
               end else begin
                  r_busy  <= 1'b0;
               end
            end
            BUSY: begin
               if (!w_req_live) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else if (r_cnt == '0) begin
                  r_state <= RESP;
                  r_ready <= 1'b1;
                  r_error <= w_bad;
                  // A rejected read reports zero; a good read exposes the RAM word.
                  if (r_op == OP_RD) r_rd_zero <= w_bad;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            RESP: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   mc_mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clk   (clk),
      .i_we  (w_we),
      .i_re  (w_re),
      .i_idx (r_idx[AW-1:0]),
      .i_wd  (r_wdata),
      .o_rd  (w_ram_rd)
   );

   // Both mux inputs are registers; the RAM read register holds between reads.
   assign rdata = r_rd_zero ? '0 : w_ram_rd;
   assign ready = r_ready;
   assign error = r_error;
   assign busy  = r_busy;

endmodule

// File: tb/tb_mc_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mc_mem_responder
// Directed self-checking bench for mc_mem_responder with hand-computed
// expectations (RD_LATENCY=2, WR_LATENCY=1, DEPTH_WORDS=1024).
// Honors MEM_ALIGN_CHECK_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_mc_mem_responder;

   localparam int DEPTH  = 1024;
   localparam int RD_LAT = 2;
   localparam int WR_LAT = 1;

   logic        clk;
   logic        rst;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        error;
   logic        busy;

   int n_vec;
   int n_err;

   mc_mem_responder #(
      .DEPTH_WORDS (DEPTH),
      .RD_LATENCY  (RD_LAT),
      .WR_LATENCY  (WR_LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .ready     (ready),
      .error     (error),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Holds the request until ready (bounded), drops it in the ready cycle and
   // checks that the pulse lasts one cycle.
   task automatic do_req(input string tag, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d,
                         input bit scramble, output int edges,
                         output logic err, output logic [31:0] rdv);
      bit seen;
      seen  = 1'b0;
      edges = 0;
      err   = 1'b0;
      rdv   = '0;
      mem_read  = rd;
      mem_write = wr;
      addr      = a;
      wdata     = d;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk); #1;
         edges++;
         if (ready) begin
            seen = 1'b1;
            err  = error;
            rdv  = rdata;
         end else if (scramble && edges == 1) begin
            addr  = a ^ 32'h3C;
            wdata = ~d;
         end
      end
      mem_read  = 1'b0;
      mem_write = 1'b0;
      chk({tag, "_ready_seen"}, {31'b0, seen}, 32'd1);
      @(posedge clk); #1;
      chk({tag, "_ready_low"}, {31'b0, ready}, 32'd0);
      chk({tag, "_busy_low"}, {31'b0, busy}, 32'd0);
   endtask

   task automatic wr_t(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic exp_err);
      int e; logic er; logic [31:0] rv;
      do_req(tag, 1'b0, 1'b1, a, d, 1'b0, e, er, rv);
      chk({tag, "_lat"}, 32'(e), 32'(WR_LAT + 1));
      chk({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
   endtask

   task automatic rd_t(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                       input logic exp_err, input bit scramble);
      int e; logic er; logic [31:0] rv;
      do_req(tag, 1'b1, 1'b0, a, 32'h0, scramble, e, er, rv);
      chk({tag, "_lat"}, 32'(e), 32'(RD_LAT + 1));
      chk({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
      chk({tag, "_rdata"}, rv, exp_d);
   endtask

   initial begin
      int e; logic er; logic [31:0] rv;
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      mem_read = 1'b0;
      mem_write = 1'b0;
      addr = '0;
      wdata = '0;
      #1;
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_ready", {31'b0, ready}, 32'd0);
      chk("rst_error", {31'b0, error}, 32'd0);
      chk("rst_busy",  {31'b0, busy},  32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Preload and read back with latency check; addr changes mid-BUSY ignored
      wr_t("wr14", 32'h14, 32'hDEADBEEF, 1'b0);
      rd_t("rd14", 32'h14, 32'hDEADBEEF, 1'b0, 1'b1);
      repeat (3) @(posedge clk);
      #1 chk("rdata_hold", rdata, 32'hDEADBEEF);

      wr_t("wr20", 32'h20, 32'h12345678, 1'b0);
      rd_t("rd20", 32'h20, 32'h12345678, 1'b0, 1'b0);

      // Conflict: immediate error response, rdata and array untouched
      wr_t("wr30", 32'h30, 32'hA5A5A5A5, 1'b0);
      do_req("conf", 1'b1, 1'b1, 32'h30, 32'hFFFF0000, 1'b0, e, er, rv);
      chk("conf_lat", 32'(e), 32'd1);
      chk("conf_err", {31'b0, er}, 32'd1);
      chk("conf_rdata", rv, 32'h12345678);
      rd_t("rd30a", 32'h30, 32'hA5A5A5A5, 1'b0, 1'b0);

      // Abort a write during BUSY
      mem_write = 1'b1;
      addr = 32'h30;
      wdata = 32'h11111111;
      @(posedge clk); #1;
      chk("abort_busy", {31'b0, busy}, 32'd1);
      mem_write = 1'b0;
      @(posedge clk); #1;
      chk("abort_ready", {31'b0, ready}, 32'd0);
      chk("abort_idle", {31'b0, busy}, 32'd0);
      repeat (2) @(posedge clk);
      #1 chk("abort_noready", {31'b0, ready}, 32'd0);
      rd_t("rd30b", 32'h30, 32'hA5A5A5A5, 1'b0, 1'b0);

      // Out of range: 0x1000 would alias word 0 if the index were truncated
      wr_t("wr00", 32'h0, 32'h0BAD0000, 1'b0);
      wr_t("wroor", 32'h1000, 32'hFFFFFFFF, 1'b1);
      rd_t("rd00", 32'h0, 32'h0BAD0000, 1'b0, 1'b0);
      rd_t("rdoor", 32'h1000, 32'h0, 1'b1, 1'b0);

`ifdef MEM_ALIGN_CHECK_EN
      wr_t("wr22", 32'h22, 32'hCAFEF00D, 1'b1);
      rd_t("rd20b", 32'h20, 32'h12345678, 1'b0, 1'b0);
      rd_t("rd22", 32'h22, 32'h0, 1'b1, 1'b0);
`else
      wr_t("wr22", 32'h22, 32'hCAFEF00D, 1'b0);
      rd_t("rd20b", 32'h20, 32'hCAFEF00D, 1'b0, 1'b0);
`endif

      // Make rdata nonzero, then reset in the middle of a write
      rd_t("rd14b", 32'h14, 32'hDEADBEEF, 1'b0, 1'b0);
      mem_write = 1'b1;
      addr = 32'h14;
      wdata = 32'h55555555;
      @(posedge clk); #1;
      chk("rstw_busy", {31'b0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rstw_busy0", {31'b0, busy}, 32'd0);
      chk("rstw_ready0", {31'b0, ready}, 32'd0);
      chk("rstw_error0", {31'b0, error}, 32'd0);
      chk("rstw_rdata0", rdata, 32'h0);
      mem_write = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rd_t("rd14c", 32'h14, 32'hDEADBEEF, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
